// File: rtl/cgra_exec_ctrl.sv
// -----------------------------------------------------------------------------
// cgra_exec_ctrl
//
// Execution controller that sits between software and a CGRA PE array.
// Software raises Computation_Start (level, four-phase handshake). The
// controller fires a one-cycle Array_Start pulse and waits a bounded time for
// PE_Array_Busy to rise. It then counts the cycles the array stays busy, with
// an optional cycle limit, and finally reports Computation_Done. Done stays
// high until software drops Computation_Start.
//
// Ports
//   Clk                in   system clock, rising edge
//   Resetn             in   asynchronous active-low reset
//   Computation_Start  in   software start request (level)
//   Computation_Done   out  kernel finished; held until Start is low
//   PE_Array_Busy      in   PE array is executing the kernel
//   Array_Start        out  one-cycle launch pulse to the PE array
//   Max_Cycles         in   run-cycle limit, 0 = unlimited
//   Cycle_Count        out  busy cycles counted in RUN for last/current kernel
//   Timeout            out  last kernel was stopped by the Max_Cycles limit
//   Ctrl_Busy          out  controller is not idle
//
// Every output is either a register or a pure decode of the state register,
// so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module cgra_exec_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int BUSY_WAIT = 4
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 Computation_Start,
  output logic                 Computation_Done,
  input  logic                 PE_Array_Busy,
  output logic                 Array_Start,
  input  logic [CNT_WIDTH-1:0] Max_Cycles,
  output logic [CNT_WIDTH-1:0] Cycle_Count,
  output logic                 Timeout,
  output logic                 Ctrl_Busy
);

  // The wait counter only has to reach BUSY_WAIT-1. It counts the Busy-low
  // cycles already spent in WAIT_BUSY.
  localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0]   cycle_cnt_reg, cycle_cnt_next;
  logic                   timeout_reg, timeout_next;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      cycle_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    cycle_cnt_next = cycle_cnt_reg;
    timeout_next   = timeout_reg;

    case (state_reg)
      IDLE: begin
        // The result registers are cleared on the way into LAUNCH. This lets
        // the LAUNCH cycle already show a fresh count. Until then the
        // previous kernel's result stays visible.
        if (Computation_Start) begin
          state_next     = LAUNCH;
          cycle_cnt_next = '0;
          timeout_next   = 1'b0;
          wait_cnt_next  = '0;
        end
      end

      LAUNCH: begin
        state_next    = WAIT_BUSY;
        wait_cnt_next = '0;
      end

      WAIT_BUSY: begin
        if (PE_Array_Busy) begin
          state_next = RUN;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Busy never came up: treat it as a zero-length kernel.
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      RUN: begin
        // A Busy fall takes priority over the limit. A kernel that ends on
        // its own in the limit cycle is not a timeout.
        if (!PE_Array_Busy) begin
          state_next = DONE;
        end else if ((Max_Cycles != '0) && (cycle_cnt_reg == Max_Cycles)) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end else if (cycle_cnt_reg != '1) begin
          cycle_cnt_next = cycle_cnt_reg + 1'b1;
        end
      end

      DONE: begin
        if (!Computation_Start) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Array_Start      = (state_reg == LAUNCH);
  assign Computation_Done = (state_reg == DONE);
  assign Ctrl_Busy        = (state_reg != IDLE);
  assign Cycle_Count      = cycle_cnt_reg;
  assign Timeout          = timeout_reg;

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cgra_exec_ctrl
//
// Bench for cgra_exec_ctrl. A narrow 4-bit counter is used so that counter
// saturation can be reached in a few cycles. Inputs change and outputs are
// sampled on the falling edge. "Cycle k" is the k-th cycle after the launch
// cycle (k = 0 is LAUNCH). A Busy value set during cycle k is sampled by the
// edge that ends cycle k.
// -----------------------------------------------------------------------------
module tb_cgra_exec_ctrl;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Resetn;
  logic          Computation_Start;
  logic          Computation_Done;
  logic          PE_Array_Busy;
  logic          Array_Start;
  logic [CW-1:0] Max_Cycles;
  logic [CW-1:0] Cycle_Count;
  logic          Timeout;
  logic          Ctrl_Busy;

  int checks   = 0;
  int failures = 0;

  cgra_exec_ctrl #(
    .CNT_WIDTH(CW),
    .BUSY_WAIT(4)
  ) dut (
    .Clk              (Clk),
    .Resetn           (Resetn),
    .Computation_Start(Computation_Start),
    .Computation_Done (Computation_Done),
    .PE_Array_Busy    (PE_Array_Busy),
    .Array_Start      (Array_Start),
    .Max_Cycles       (Max_Cycles),
    .Cycle_Count      (Cycle_Count),
    .Timeout          (Timeout),
    .Ctrl_Busy        (Ctrl_Busy)
  );

  always #5 Clk = ~Clk;

  // One kernel scenario: Busy is high for cycles b0 .. b0+blen-1.
  // 'early' drops Start in cycle 2. Done is expected first in cycle done_k.
  typedef struct {
    logic [CW-1:0] max;
    int            b0;
    int            blen;
    bit            early;
    logic [CW-1:0] exp_cnt;
    logic          exp_to;
    int            done_k;
  } scn_t;

  scn_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy_at(input scn_t s, input int k);
    return (k >= s.b0) && (k < s.b0 + s.blen);
  endfunction

  task automatic run_scn(input int idx, input scn_t s);
    Max_Cycles        = s.max;
    PE_Array_Busy     = 1'b0;
    Computation_Start = 1'b1;
    @(negedge Clk);  // k = 0 : LAUNCH
    chk("launch_pulse", 32'(Array_Start), 32'd1);
    chk("launch_busy", 32'(Ctrl_Busy), 32'd1);
    chk("launch_cnt_clr", 32'(Cycle_Count), 32'd0);
    chk("launch_to_clr", 32'(Timeout), 32'd0);
    PE_Array_Busy = busy_at(s, 0);
    for (int k = 1; k <= s.done_k; k++) begin
      @(negedge Clk);
      chk("array_start_once", 32'(Array_Start), 32'd0);
      if (k < s.done_k) begin
        chk("done_early", 32'(Computation_Done), 32'd0);
      end else begin
        chk("done_rise", 32'(Computation_Done), 32'd1);
        chk("done_cnt", 32'(Cycle_Count), 32'(s.exp_cnt));
        chk("done_timeout", 32'(Timeout), 32'(s.exp_to));
      end
      if (s.early && k == 2) Computation_Start = 1'b0;
      PE_Array_Busy = busy_at(s, k);
    end
    @(negedge Clk);  // cycle done_k + 1
    if (s.early) begin
      chk("done_one_cycle", 32'(Computation_Done), 32'd0);
      chk("idle_after_early", 32'(Ctrl_Busy), 32'd0);
    end else begin
      chk("done_held", 32'(Computation_Done), 32'd1);
      Computation_Start = 1'b0;
      @(negedge Clk);
      chk("done_drop", 32'(Computation_Done), 32'd0);
      chk("idle_after_done", 32'(Ctrl_Busy), 32'd0);
    end
    chk("cnt_held_idle", 32'(Cycle_Count), 32'(s.exp_cnt));
    chk("to_held_idle", 32'(Timeout), 32'(s.exp_to));
    PE_Array_Busy = 1'b0;
    $display("scenario %0d max=%0d busy@%0d len=%0d early=%0d -> count=%0d timeout=%0d",
             idx, s.max, s.b0, s.blen, s.early, Cycle_Count, Timeout);
  endtask

  initial begin
    //        max   b0 blen early cnt  to done_k
    tbl[0] = '{4'd0, 3, 11, 1'b0, 4'd10, 1'b0, 15}; // normal kernel
    tbl[1] = '{4'd5, 1, 100, 1'b0, 4'd5, 1'b1, 8};  // limit reached, Busy stays high
    tbl[2] = '{4'd0, 1, 0, 1'b0, 4'd0, 1'b0, 5};    // Busy never rises
    tbl[3] = '{4'd0, 2, 7, 1'b1, 4'd6, 1'b0, 10};   // Start dropped mid-kernel
    tbl[4] = '{4'd8, 2, 9, 1'b0, 4'd8, 1'b0, 12};   // Busy fall == limit cycle
    tbl[5] = '{4'd0, 4, 3, 1'b0, 4'd2, 1'b0, 8};    // Busy on last wait cycle
    tbl[6] = '{4'd0, 5, 3, 1'b0, 4'd0, 1'b0, 5};    // Busy one cycle too late
    tbl[7] = '{4'd0, 1, 21, 1'b0, 4'd15, 1'b0, 23}; // counter saturates
    tbl[8] = '{4'd3, 1, 3, 1'b0, 4'd2, 1'b0, 5};    // ends one short of limit

    Resetn            = 1'b0;
    Computation_Start = 1'b0;
    PE_Array_Busy     = 1'b0;
    Max_Cycles        = '0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_done", 32'(Computation_Done), 32'd0);
    chk("rst_array_start", 32'(Array_Start), 32'd0);
    chk("rst_cnt", 32'(Cycle_Count), 32'd0);
    chk("rst_timeout", 32'(Timeout), 32'd0);
    chk("rst_ctrl_busy", 32'(Ctrl_Busy), 32'd0);
    Resetn = 1'b1;
    @(negedge Clk);
    chk("idle_no_launch", 32'(Array_Start), 32'd0);

    for (int i = 0; i < 9; i++) run_scn(i, tbl[i]);

    // Reset in the middle of RUN, once Cycle_Count has reached 6.
    Max_Cycles        = '0;
    Computation_Start = 1'b1;
    @(negedge Clk);  // k = 0
    chk("mid_launch", 32'(Array_Start), 32'd1);
    PE_Array_Busy = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge Clk);
    chk("mid_cnt6", 32'(Cycle_Count), 32'd6);
    #1 Resetn = 1'b0;
    #1;
    chk("async_done", 32'(Computation_Done), 32'd0);
    chk("async_array_start", 32'(Array_Start), 32'd0);
    chk("async_cnt", 32'(Cycle_Count), 32'd0);
    chk("async_timeout", 32'(Timeout), 32'd0);
    chk("async_ctrl_busy", 32'(Ctrl_Busy), 32'd0);
    Computation_Start = 1'b0;
    PE_Array_Busy     = 1'b0;
    @(negedge Clk);
    Resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("post_rst_no_done", 32'(Computation_Done), 32'd0);
      chk("post_rst_idle", 32'(Ctrl_Busy), 32'd0);
    end
    run_scn(9, tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_exec_ctrl.md
CGRA_EXEC_CTRL -- requirements
Module: cgra_exec_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of cycle counter and timeout limit.
REQ-002 Parameter BUSY_WAIT, default 4: max cycles to wait for PE_Array_Busy rise after launch.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Computation_Start  input  1  software start request, level, four-phase handshake.
REQ-006 Computation_Done  output  1  kernel finished, held until Computation_Start low.
REQ-007 PE_Array_Busy  input  1  PE array executing kernel.
REQ-008 Array_Start  output  1  one-cycle launch pulse to PE array.
REQ-009 Max_Cycles  input  CNT_WIDTH  run-cycle limit; 0 = no limit.
REQ-010 Cycle_Count  output  CNT_WIDTH  cycles spent in RUN for last/current kernel.
REQ-011 Timeout  output  1  last kernel ended by Max_Cycles limit, not by Busy fall.
REQ-012 Ctrl_Busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, RUN, DONE; one state per cycle minimum.
REQ-014 IDLE: Computation_Start sampled high -> LAUNCH next cycle; else stay.
REQ-015 LAUNCH: Array_Start=1 for exactly this cycle; Cycle_Count cleared to 0, Timeout cleared to 0, wait counter cleared; -> WAIT_BUSY.
REQ-016 Array_Start SHALL be high in the cycle after Start is first sampled high in IDLE (latency 1) and never otherwise.
REQ-017 WAIT_BUSY: PE_Array_Busy high -> RUN; else wait counter increments; after BUSY_WAIT cycles with Busy low -> DONE (zero-length kernel, Cycle_Count stays 0, Timeout 0).
REQ-018 RUN: Cycle_Count increments by 1 each cycle in RUN, saturating at all-ones (no wrap).
REQ-019 RUN: PE_Array_Busy sampled low -> DONE, Cycle_Count not incremented that cycle.
REQ-020 RUN: Max_Cycles!=0 and Cycle_Count==Max_Cycles with Busy high -> DONE, Timeout=1.
REQ-021 Busy low and limit reached in same cycle: Busy-fall wins, Timeout=0.
REQ-022 DONE: Computation_Done=1; Computation_Start sampled low -> IDLE, Done low next cycle; Done high for at least one cycle.
REQ-023 Computation_Start deassert during LAUNCH/WAIT_BUSY/RUN SHALL be ignored; sequence completes, DONE lasts exactly one cycle.
REQ-024 Start held high after returning to IDLE is impossible (DONE requires Start low); re-launch needs a new Start rise.
REQ-025 Cycle_Count and Timeout SHALL hold their values from DONE through IDLE until next LAUNCH.
REQ-026 Max_Cycles SHALL be sampled every RUN cycle (no latching); software keeps it stable during a kernel.
REQ-027 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-028 Resetn low SHALL force, asynchronously: state IDLE, Computation_Done 0, Array_Start 0, Cycle_Count 0, Timeout 0, Ctrl_Busy 0, wait counter 0.
REQ-029 Reset asserted mid-kernel SHALL abort with no Done; after release, FSM SHALL launch only on Computation_Start sampled high in IDLE.
REQ-030 First rising edge after Resetn release SHALL be a normal IDLE evaluation.

Verification
REQ-031 Normal: Max_Cycles=0, Start high at edge 0, Busy high 3 cycles after Array_Start for 10 cycles -> one Array_Start pulse at cycle 1, Cycle_Count=10, Timeout=0, Done high until Start dropped, then low next cycle.
REQ-032 Timeout: Max_Cycles=5, Busy held high -> DONE after Cycle_Count=5, Timeout=1, Done=1; Busy still high is ignored.
REQ-033 No-busy: Busy never rises -> DONE after BUSY_WAIT=4 wait cycles, Cycle_Count=0, Timeout=0.
REQ-034 Early Start drop: Start low during RUN -> kernel completes, Done high exactly 1 cycle, FSM IDLE; second Start rise relaunches with Cycle_Count cleared.
REQ-035 Collision: Max_Cycles=8, Busy falls in the cycle Cycle_Count==8 -> Timeout=0, Cycle_Count=8.
REQ-036 Reset mid-RUN at Cycle_Count=6 -> all outputs 0 immediately (before next edge), no Done pulse, clean relaunch afterwards.
